// File: rtl/pipelined_array_multiplier_pkg.sv
// Shared definitions for the pipelined array multiplier: default geometry and
// the operand magnitude helper used by the input conditioning logic.
package mult_pkg;

   localparam int DEF_WIDTH      = 8;
   localparam int DEF_STAGES     = 4;
   localparam int DEF_TAG_W      = 4;
   localparam int ROWS_PER_STAGE = DEF_WIDTH / DEF_STAGES;

   // Operands are extended to MAX_W bits before taking the magnitude, so the
   // most negative WIDTH-bit value negates without wrapping.
   localparam int MAX_W = 64;

   function automatic logic [MAX_W-1:0] abs_mag(input logic [MAX_W-1:0] value,
                                                input logic             is_signed);
      if (is_signed && value[MAX_W-1]) begin
         abs_mag = ~value + 1'b1;
      end else begin
         abs_mag = value;
      end
   endfunction

endpackage

// File: rtl/pipelined_array_multiplier_stage.sv
// One multiplier pipeline stage: adds ROWS partial-product rows into the running
// sum with ripple rows of full adders, then registers the payload with a hold enable.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);
   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

module mult_stage #(
   parameter int WIDTH    = 8,
   parameter int ROWS     = 2,
   parameter int ROW_BASE = 0,
   parameter int TAG_W    = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic                 in_valid,
   input  logic [2*WIDTH-1:0]   in_sum,
   input  logic [WIDTH-1:0]     in_mag_a,
   input  logic [WIDTH-1:0]     in_mag_b,
   input  logic                 in_neg,
   input  logic [TAG_W-1:0]     in_tag,
   output logic                 out_valid,
   output logic [2*WIDTH-1:0]   out_sum,
   output logic [WIDTH-1:0]     out_mag_a,
   output logic [WIDTH-1:0]     out_mag_b,
   output logic                 out_neg,
   output logic [TAG_W-1:0]     out_tag
);
   localparam int PW = 2 * WIDTH;

   typedef struct packed {
      logic [PW-1:0]    sum;
      logic [WIDTH-1:0] mag_a;
      logic [WIDTH-1:0] mag_b;
      logic             neg;
      logic [TAG_W-1:0] tag;
   } payload_t;

   wire  [PW-1:0] acc    [ROWS+1];
   wire  [PW:0]   carry  [ROWS];
   logic [PW-1:0] row_pp [ROWS];
   logic [ROWS-1:0] unused_cout;
   payload_t q;

   assign acc[0] = in_sum;

   for (genvar r = 0; r < ROWS; r++) begin : g_row
      assign row_pp[r]      = PW'(in_mag_a & {WIDTH{in_mag_b[ROW_BASE+r]}}) << (ROW_BASE + r);
      assign carry[r][0]    = 1'b0;
      // The running sum never exceeds 2*WIDTH bits, so each row's final carry is always zero.
      assign unused_cout[r] = carry[r][PW];
      for (genvar b = 0; b < PW; b++) begin : g_bit
         full_adder u_fa (
            .a    (acc[r][b]),
            .b    (row_pp[r][b]),
            .cin  (carry[r][b]),
            .s    (acc[r+1][b]),
            .cout (carry[r][b+1])
         );
      end
   end

   // NOTE: state is updated with non-blocking assignments so every stage samples its
   // predecessor's pre-edge value; the datapath is reset too so out_p/out_tag read 0 after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         q         <= '0;
      end else if (en) begin
         out_valid <= in_valid;
         if (in_valid) begin
            q <= '{sum: acc[ROWS], mag_a: in_mag_a, mag_b: in_mag_b, neg: in_neg, tag: in_tag};
         end
      end
   end

   assign out_sum   = q.sum;
   assign out_mag_a = q.mag_a;
   assign out_mag_b = q.mag_b;
   assign out_neg   = q.neg;
   assign out_tag   = q.tag;

endmodule

// File: rtl/pipelined_array_multiplier.sv
// Pipelined WIDTH x WIDTH array multiplier, signed or unsigned per operation, with
// valid/ready on both sides and a global stall driven by output backpressure.
module pipelined_array_multiplier
   import mult_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int STAGES = DEF_STAGES,
   parameter int TAG_W  = DEF_TAG_W
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [WIDTH-1:0]    in_a,
   input  logic [WIDTH-1:0]    in_b,
   input  logic                in_signed,
   input  logic [TAG_W-1:0]    in_tag,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [2*WIDTH-1:0]  out_p,
   output logic [TAG_W-1:0]    out_tag,
   output logic                busy
);
   localparam int ROWS = WIDTH / STAGES;

   if (WIDTH < 2 || WIDTH > MAX_W / 2 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
      $error("pipelined_array_multiplier: WIDTH must be 2..32 and a multiple of STAGES (1..WIDTH)");
   end

   logic [STAGES-1:0]  stage_vld;
   logic [2*WIDTH-1:0] sum   [STAGES+1];
   logic [WIDTH-1:0]   mag_a [STAGES+1];
   logic [WIDTH-1:0]   mag_b [STAGES+1];
   logic [STAGES:0]    neg;
   logic [TAG_W-1:0]   tag   [STAGES+1];
   logic               stall;
   logic               unused_tail;

   // Operands are sign- or zero-extended so abs_mag sees the true value.
   assign mag_a[0] = WIDTH'(abs_mag(in_signed ? MAX_W'($signed(in_a)) : MAX_W'(in_a), in_signed));
   assign mag_b[0] = WIDTH'(abs_mag(in_signed ? MAX_W'($signed(in_b)) : MAX_W'(in_b), in_signed));
   assign neg[0]   = in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
   assign sum[0]   = '0;
   assign tag[0]   = in_tag;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic vld_in;
      if (k == 0) begin : g_first
         assign vld_in = in_valid;
      end else begin : g_next
         assign vld_in = stage_vld[k-1];
      end

      mult_stage #(
         .WIDTH    (WIDTH),
         .ROWS     (ROWS),
         .ROW_BASE (k * ROWS),
         .TAG_W    (TAG_W)
      ) u_stage (
         .clk       (clk),
         .rst_n     (rst_n),
         .en        (~stall),
         .in_valid  (vld_in),
         .in_sum    (sum[k]),
         .in_mag_a  (mag_a[k]),
         .in_mag_b  (mag_b[k]),
         .in_neg    (neg[k]),
         .in_tag    (tag[k]),
         .out_valid (stage_vld[k]),
         .out_sum   (sum[k+1]),
         .out_mag_a (mag_a[k+1]),
         .out_mag_b (mag_b[k+1]),
         .out_neg   (neg[k+1]),
         .out_tag   (tag[k+1])
      );
   end

   assign unused_tail = ^{mag_a[STAGES], mag_b[STAGES]};

   // Stall is global: bubbles are held in place rather than squeezed out.
   assign out_valid = stage_vld[STAGES-1];
   assign stall     = out_valid & ~out_ready;
   assign in_ready  = ~stall;
   assign busy      = |stage_vld;

   // Negating a zero magnitude yields zero, so -0 never appears.
   assign out_p   = neg[STAGES] ? (~sum[STAGES] + 1'b1) : sum[STAGES];
   assign out_tag = tag[STAGES];

endmodule

// File: tb/tb_pipelined_array_multiplier.sv
// Directed bench for pipelined_array_multiplier (WIDTH=8, STAGES=4): reset, latency,
// signed corners, streaming, backpressure, async reset mid-flight and a short random run.
module tb_pipelined_array_multiplier;
   localparam int WIDTH  = 8;
   localparam int STAGES = 4;
   localparam int TAG_W  = 4;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   in_a;
   logic [WIDTH-1:0]   in_b;
   logic               in_signed;
   logic [TAG_W-1:0]   in_tag;
   logic               out_valid;
   logic               out_ready;
   logic [2*WIDTH-1:0] out_p;
   logic [TAG_W-1:0]   out_tag;
   logic               busy;

   typedef struct {
      logic [2*WIDTH-1:0] p;
      logic [TAG_W-1:0]   tag;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cycle = 0;
   int   xfer_cnt;
   int   first_xfer;
   int   last_xfer;
   int   in_ready_low;

   always #5 clk = ~clk;

   pipelined_array_multiplier #(.WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_signed (in_signed),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_p     (out_p),
      .out_tag   (out_tag),
      .busy      (busy)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   function automatic logic [2*WIDTH-1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                input logic s);
      logic signed [2*WIDTH-1:0] sp;
      if (s) begin
         sp = $signed(a) * $signed(b);
         return sp;
      end
      return (2*WIDTH)'(a) * (2*WIDTH)'(b);
   endfunction

   // One cycle: drive at the falling edge, sample 1ns later, score any transfer.
   task automatic step(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic s, input logic [TAG_W-1:0] t, input logic [2*WIDTH-1:0] exp_p,
                       input logic ordy, output logic acc);
      exp_t e;
      @(negedge clk);
      in_valid  = v;
      in_a      = a;
      in_b      = b;
      in_signed = s;
      in_tag    = t;
      out_ready = ordy;
      #1;
      cycle++;
      acc = v && in_ready;
      if (acc) exp_q.push_back('{p: exp_p, tag: t});
      if (!in_ready) in_ready_low++;
      if (out_valid && out_ready) begin
         xfer_cnt++;
         if (first_xfer < 0) first_xfer = cycle;
         last_xfer = cycle;
         if (exp_q.size() == 0) begin
            check("unexpected_out", 32'(out_tag), 32'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            check("out_p", 32'(out_p), 32'(e.p));
            check("out_tag", 32'(out_tag), 32'(e.tag));
         end
      end
   endtask

   task automatic idle(input logic ordy);
      logic acc;
      step(1'b0, '0, '0, 1'b0, '0, '0, ordy, acc);
   endtask

   task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s,
                       input logic [TAG_W-1:0] t, input logic [2*WIDTH-1:0] exp_p, input logic ordy);
      logic acc;
      step(1'b1, a, b, s, t, exp_p, ordy, acc);
      check("accept", 32'(acc), 32'd1);
   endtask

   task automatic drain(input int budget);
      for (int i = 0; i < budget && exp_q.size() > 0; i++) idle(1'b1);
      check("drain_empty", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      logic acc;
      int   lat;
      int   seen;
      int   ops;
      logic [WIDTH-1:0] ra, rb;
      logic rs, have;

      rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0;
      in_tag = '0; out_ready = 1'b0;
      xfer_cnt = 0; first_xfer = -1; last_xfer = -1; in_ready_low = 0;
      #12;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_p", 32'(out_p), 32'd0);
      check("rst_out_tag", 32'(out_tag), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Unsigned full-scale product and latency counted from the cycle of accept.
      send(8'hFF, 8'hFF, 1'b0, 4'h1, 16'hFE01, 1'b1);
      lat = 0;
      for (int i = 0; i < 10; i++) begin
         idle(1'b1);
         lat++;
         if (out_valid) break;
      end
      check("latency", 32'(lat), 32'(STAGES));
      idle(1'b1);
      check("single_result", 32'(out_valid), 32'd0);

      // Signed corner cases plus one unsigned reference.
      send(8'h80, 8'h80, 1'b1, 4'h2, 16'h4000, 1'b1);
      send(8'h80, 8'h7F, 1'b1, 4'h3, 16'hC080, 1'b1);
      send(8'hFF, 8'h01, 1'b1, 4'h4, 16'hFFFF, 1'b1);
      send(8'h00, 8'h80, 1'b1, 4'h5, 16'h0000, 1'b1);
      send(8'h80, 8'h7F, 1'b0, 4'h6, 16'h3F80, 1'b1);
      send(8'hFE, 8'hFE, 1'b1, 4'h7, 16'h0004, 1'b1);
      drain(20);

      // Back-to-back streaming.
      xfer_cnt = 0; first_xfer = -1; in_ready_low = 0;
      for (int i = 0; i < 16; i++) begin
         ra = 8'(i * 17);
         rb = 8'(8'hF0 - i * 3);
         send(ra, rb, i[0], 4'(i), model(ra, rb, i[0]), 1'b1);
      end
      drain(20);
      check("stream_xfers", 32'(xfer_cnt), 32'd16);
      check("stream_span", 32'(last_xfer - first_xfer + 1), 32'd16);
      check("stream_in_ready_low", 32'(in_ready_low), 32'd0);

      // Backpressure: fill the pipe, hold the output for 5 cycles, then drain.
      xfer_cnt = 0;
      send(8'h03, 8'h05, 1'b0, 4'h8, 16'h000F, 1'b0);
      send(8'h12, 8'h34, 1'b0, 4'h9, 16'h03A8, 1'b0);
      send(8'hFE, 8'h03, 1'b1, 4'hA, 16'hFFFA, 1'b0);
      send(8'hC8, 8'h02, 1'b0, 4'hB, 16'h0190, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 8'h11, 8'h11, 1'b0, 4'hF, 16'h0121, 1'b0, acc);
         check("stall_accept", 32'(acc), 32'd0);
         check("stall_in_ready", 32'(in_ready), 32'd0);
         check("stall_out_valid", 32'(out_valid), 32'd1);
         check("stall_out_p", 32'(out_p), 32'h000F);
         check("stall_out_tag", 32'(out_tag), 32'h8);
      end
      drain(20);
      for (int i = 0; i < 6; i++) idle(1'b1);
      check("bp_xfers", 32'(xfer_cnt), 32'd4);

      // Asynchronous reset with three operations in flight.
      send(8'h05, 8'h06, 1'b0, 4'h1, 16'h001E, 1'b1);
      send(8'h07, 8'h08, 1'b0, 4'h2, 16'h0038, 1'b1);
      send(8'h09, 8'h0A, 1'b0, 4'h3, 16'h005A, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      #2;
      check("pre_rst_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         idle(1'b1);
         if (out_valid) seen++;
      end
      check("post_rst_no_output", 32'(seen), 32'd0);

      // Short random run with random valid/ready; the source holds an op until accepted.
      ops = 0; have = 1'b0; ra = '0; rb = '0; rs = 1'b0;
      for (int i = 0; i < 3000 && ops < 300; i++) begin
         if (!have) begin
            ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom); have = 1'b1;
         end
         step(($urandom_range(0, 3) != 0), ra, rb, rs, 4'(ops), model(ra, rb, rs),
              ($urandom_range(0, 3) != 0), acc);
         if (acc) begin
            have = 1'b0;
            ops++;
         end
      end
      check("random_ops", 32'(ops), 32'd300);
      drain(50);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
